// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave register-bank controller.
package i2c_pkg;

   localparam int I2C_REG_NUM_DEF = 16;
   localparam int I2C_PTR_W_DEF   = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PTR,
      ST_WDATA,
      ST_RDATA,
      ST_DONE
   } i2c_state_t;

endpackage

// File: rtl/i2c_reg_file.sv
// REG_NUM x 8 register file: one I2C write port, one local write port,
// an asynchronous I2C read port and a registered write-first local read port.
module i2c_reg_file
   import i2c_pkg::*;
#(
   parameter int REG_NUM = I2C_REG_NUM_DEF,
   parameter int ADDR_W  = I2C_PTR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i2c_we,
   input  logic [ADDR_W-1:0] i2c_addr,
   input  logic [7:0]        i2c_wdata,
   input  logic [ADDR_W-1:0] i2c_raddr,
   output logic [7:0]        i2c_rdata,
   input  logic              usr_we,
   input  logic [ADDR_W-1:0] usr_addr,
   input  logic [7:0]        usr_wdata,
   output logic [7:0]        usr_rdata
);

   logic [7:0] mem [REG_NUM];

   // The I2C port wins a same-address collision; other local writes proceed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_NUM; i++) mem[i] <= 8'h00;
      end else begin
         for (int i = 0; i < REG_NUM; i++) begin
            if (i2c_we && i2c_addr == ADDR_W'(i))
               mem[i] <= i2c_wdata;
            else if (usr_we && usr_addr == ADDR_W'(i))
               mem[i] <= usr_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         usr_rdata <= 8'h00;
      else if (i2c_we && i2c_addr == usr_addr)
         usr_rdata <= i2c_wdata;
      else if (usr_we)
         usr_rdata <= usr_wdata;
      else
         usr_rdata <= mem[usr_addr];
   end

   assign i2c_rdata = mem[i2c_raddr];

endmodule

// File: rtl/i2c_slave_reg_ctrl.sv
// Register-bank controller sequencing the I2C slave byte engine (pointer byte, then data).
// Define I2C_REG_AUTOINC_EN to auto-increment the pointer after each data byte.
module i2c_slave_reg_ctrl
   import i2c_pkg::*;
#(
   parameter int REG_NUM = I2C_REG_NUM_DEF,
   parameter int ADDR_W  = I2C_PTR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic              slave_en,
   output logic              rd_clr,
   output logic              wr_rdy,
   output logic [7:0]        byte_wr_o,
   input  logic              rd_reg_full,
   input  logic              wr_reg_empty,
   input  logic [7:0]        byte_rd_i,
   input  logic              addr_match,
   input  logic              trans_dir,
   input  logic              get_nack,
   input  logic              trans_stop,
   input  logic              bus_err,
   input  logic              usr_we,
   input  logic [ADDR_W-1:0] usr_addr,
   input  logic [7:0]        usr_wdata,
   output logic [7:0]        usr_rdata,
   output logic              i2c_wr_stb,
   output logic [ADDR_W-1:0] i2c_wr_addr,
   output logic              busy,
   output logic              err
);

   i2c_state_t        state, state_d;
   logic [ADDR_W-1:0] ptr;
   logic              addr_match_q;
   logic              am_rise;
   logic              rx_fire, ptr_load, wr_fire, tx_fire;
   logic [7:0]        tx_data;

   assign am_rise = addr_match & ~addr_match_q;
   assign busy    = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_d;
   end

   // Abort conditions outrank a repeated start, which outranks byte handling.
   always_comb begin
      state_d  = state;
      rx_fire  = 1'b0;
      ptr_load = 1'b0;
      wr_fire  = 1'b0;
      tx_fire  = 1'b0;
      if (!en || trans_stop || bus_err) begin
         state_d = ST_IDLE;
      end else if (am_rise) begin
         state_d = trans_dir ? ST_RDATA : ST_PTR;
      end else if (state != ST_IDLE) begin
         rx_fire = rd_reg_full && !trans_dir && !rd_clr;
         case (state)
            ST_PTR: begin
               if (rx_fire) begin
                  ptr_load = 1'b1;
                  state_d  = ST_WDATA;
               end
            end
            ST_WDATA: wr_fire = rx_fire;
            ST_RDATA: begin
               if (get_nack)
                  state_d = ST_DONE;
               else
                  tx_fire = wr_reg_empty && !wr_rdy;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slave_en     <= 1'b0;
         addr_match_q <= 1'b0;
         rd_clr       <= 1'b0;
         wr_rdy       <= 1'b0;
         byte_wr_o    <= 8'h00;
         i2c_wr_stb   <= 1'b0;
         i2c_wr_addr  <= '0;
         ptr          <= '0;
         err          <= 1'b0;
      end else begin
         slave_en     <= en;
         addr_match_q <= addr_match;
         rd_clr       <= rx_fire;
         wr_rdy       <= tx_fire;
         i2c_wr_stb   <= wr_fire;
         if (wr_fire) i2c_wr_addr <= ptr;
         if (tx_fire) byte_wr_o <= tx_data;
         if (ptr_load)
            ptr <= byte_rd_i[ADDR_W-1:0];
`ifdef I2C_REG_AUTOINC_EN
         else if (wr_fire || tx_fire)
            ptr <= ptr + ADDR_W'(1);
`endif
         if (!en)         err <= 1'b0;
         else if (bus_err) err <= 1'b1;
      end
   end

   i2c_reg_file #(
      .REG_NUM (REG_NUM),
      .ADDR_W  (ADDR_W)
   ) u_reg_file (
      .clk       (clk),
      .rst_n     (rst_n),
      .i2c_we    (wr_fire),
      .i2c_addr  (ptr),
      .i2c_wdata (byte_rd_i),
      .i2c_raddr (ptr),
      .i2c_rdata (tx_data),
      .usr_we    (usr_we),
      .usr_addr  (usr_addr),
      .usr_wdata (usr_wdata),
      .usr_rdata (usr_rdata)
   );

endmodule

// File: tb/tb_i2c_slave_reg_ctrl.sv
// Directed self-checking bench for i2c_slave_reg_ctrl; expectations follow I2C_REG_AUTOINC_EN.
module tb_i2c_slave_reg_ctrl;

`ifdef I2C_REG_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       slave_en, rd_clr, wr_rdy;
   logic [7:0] byte_wr_o;
   logic       rd_reg_full, wr_reg_empty;
   logic [7:0] byte_rd_i;
   logic       addr_match, trans_dir, get_nack, trans_stop, bus_err;
   logic       usr_we;
   logic [3:0] usr_addr;
   logic [7:0] usr_wdata, usr_rdata;
   logic       i2c_wr_stb;
   logic [3:0] i2c_wr_addr;
   logic       busy, err;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   i2c_slave_reg_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .slave_en     (slave_en),
      .rd_clr       (rd_clr),
      .wr_rdy       (wr_rdy),
      .byte_wr_o    (byte_wr_o),
      .rd_reg_full  (rd_reg_full),
      .wr_reg_empty (wr_reg_empty),
      .byte_rd_i    (byte_rd_i),
      .addr_match   (addr_match),
      .trans_dir    (trans_dir),
      .get_nack     (get_nack),
      .trans_stop   (trans_stop),
      .bus_err      (bus_err),
      .usr_we       (usr_we),
      .usr_addr     (usr_addr),
      .usr_wdata    (usr_wdata),
      .usr_rdata    (usr_rdata),
      .i2c_wr_stb   (i2c_wr_stb),
      .i2c_wr_addr  (i2c_wr_addr),
      .busy         (busy),
      .err          (err)
   );

   task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic startTxn(input logic dir);
      trans_dir  = dir;
      addr_match = 1'b1;
      applyStimulus();
      addr_match = 1'b0;
   endtask

   task automatic stopTxn();
      trans_stop = 1'b1;
      applyStimulus();
      trans_stop = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b, input string tag, input logic stb, input logic [3:0] addr);
      byte_rd_i   = b;
      rd_reg_full = 1'b1;
      applyStimulus();
      checkOutput({tag, "_rd_clr"}, 16'(rd_clr), 16'h1);
      checkOutput({tag, "_stb"}, 16'(i2c_wr_stb), 16'(stb));
      if (stb) checkOutput({tag, "_addr"}, 16'(i2c_wr_addr), 16'(addr));
      rd_reg_full = 1'b0;
      applyStimulus();
   endtask

   task automatic readUsr(input logic [3:0] a, input string tag, input logic [7:0] exp);
      usr_addr = a;
      applyStimulus();
      checkOutput(tag, 16'(usr_rdata), 16'(exp));
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0;
      rd_reg_full = 0; wr_reg_empty = 0; byte_rd_i = 0;
      addr_match = 0; trans_dir = 0; get_nack = 0; trans_stop = 0; bus_err = 0;
      usr_we = 0; usr_addr = 0; usr_wdata = 0;
      repeat (2) applyStimulus();
      checkOutput("rst_slave_en", 16'(slave_en), 16'h0);
      checkOutput("rst_busy", 16'(busy), 16'h0);
      checkOutput("rst_outs", {rd_clr, wr_rdy, i2c_wr_stb, err, 4'(i2c_wr_addr), byte_wr_o}, 16'h0);
      checkOutput("rst_usr_rdata", 16'(usr_rdata), 16'h0);
      rst_n = 1'b1; en = 1'b1;
      applyStimulus();
      checkOutput("slave_en_on", 16'(slave_en), 16'h1);

      // Pointer 3, then two data bytes
      startTxn(1'b0);
      checkOutput("a_busy", 16'(busy), 16'h1);
      sendByte(8'h03, "a_ptr", 1'b0, 4'd0);
      sendByte(8'hA5, "a_d0", 1'b1, 4'd3);
      sendByte(8'h5A, "a_d1", 1'b1, AUTOINC ? 4'd4 : 4'd3);
      stopTxn();
      checkOutput("a_idle", 16'(busy), 16'h0);
      readUsr(4'd3, "a_reg3", AUTOINC ? 8'hA5 : 8'h5A);
      readUsr(4'd4, "a_reg4", AUTOINC ? 8'h5A : 8'h00);

      // Pointer 15 with ignored upper bits, wrap to 0
      startTxn(1'b0);
      sendByte(8'h3F, "b_ptr", 1'b0, 4'd0);
      sendByte(8'h11, "b_d0", 1'b1, 4'd15);
      sendByte(8'h22, "b_d1", 1'b1, AUTOINC ? 4'd0 : 4'd15);
      stopTxn();
      readUsr(4'd15, "b_reg15", AUTOINC ? 8'h11 : 8'h22);
      readUsr(4'd0, "b_reg0", AUTOINC ? 8'h22 : 8'h00);

      // Local preload, then write pointer 2, repeated start, read 2 with NACK
      usr_we = 1'b1; usr_addr = 4'd2; usr_wdata = 8'hC2;
      applyStimulus();
      checkOutput("c_usr_wfirst", 16'(usr_rdata), 16'h00C2);
      usr_addr = 4'd3; usr_wdata = 8'hC3;
      applyStimulus();
      usr_we = 1'b0;
      startTxn(1'b0);
      sendByte(8'h02, "c_ptr", 1'b0, 4'd0);
      startTxn(1'b1);
      checkOutput("c_rs_busy", 16'(busy), 16'h1);
      wr_reg_empty = 1'b1;
      applyStimulus();
      checkOutput("c_rdy0", 16'(wr_rdy), 16'h1);
      checkOutput("c_byte0", 16'(byte_wr_o), 16'h00C2);
      applyStimulus();
      checkOutput("c_rdy_gap", 16'(wr_rdy), 16'h0);
      wr_reg_empty = 1'b0;
      applyStimulus();
      wr_reg_empty = 1'b1;
      applyStimulus();
      checkOutput("c_rdy1", 16'(wr_rdy), 16'h1);
      checkOutput("c_byte1", 16'(byte_wr_o), AUTOINC ? 16'h00C3 : 16'h00C2);
      wr_reg_empty = 1'b0;
      applyStimulus();
      get_nack = 1'b1; wr_reg_empty = 1'b1;
      applyStimulus();
      checkOutput("c_nack_rdy", 16'(wr_rdy), 16'h0);
      get_nack = 1'b0;
      applyStimulus();
      checkOutput("c_done_rdy", 16'(wr_rdy), 16'h0);
      checkOutput("c_done_busy", 16'(busy), 16'h1);
      checkOutput("c_byte_hold", 16'(byte_wr_o), AUTOINC ? 16'h00C3 : 16'h00C2);
      wr_reg_empty = 1'b0;
      stopTxn();
      checkOutput("c_stop_idle", 16'(busy), 16'h0);

      // Same-address collision: I2C write wins
      startTxn(1'b0);
      sendByte(8'h05, "d_ptr", 1'b0, 4'd0);
      usr_we = 1'b1; usr_addr = 4'd5; usr_wdata = 8'h99;
      byte_rd_i = 8'h77; rd_reg_full = 1'b1;
      applyStimulus();
      checkOutput("d_stb", 16'(i2c_wr_stb), 16'h1);
      checkOutput("d_rdata_now", 16'(usr_rdata), 16'h0077);
      usr_we = 1'b0; rd_reg_full = 1'b0;
      applyStimulus();
      checkOutput("d_rdata_next", 16'(usr_rdata), 16'h0077);
      stopTxn();

      // Bus error mid-WDATA, then disable
      startTxn(1'b0);
      sendByte(8'h08, "e_ptr", 1'b0, 4'd0);
      bus_err = 1'b1;
      applyStimulus();
      bus_err = 1'b0;
      checkOutput("e_err", 16'(err), 16'h1);
      checkOutput("e_idle", 16'(busy), 16'h0);
      applyStimulus();
      checkOutput("e_err_sticky", 16'(err), 16'h1);
      en = 1'b0;
      applyStimulus();
      checkOutput("e_err_clr", 16'(err), 16'h0);
      checkOutput("e_slave_en", 16'(slave_en), 16'h0);
      en = 1'b1;
      applyStimulus();

      // Pointer 7, three bytes; last byte holds rd_reg_full for two cycles
      startTxn(1'b0);
      sendByte(8'h07, "f_ptr", 1'b0, 4'd0);
      sendByte(8'h31, "f_d0", 1'b1, 4'd7);
      sendByte(8'h32, "f_d1", 1'b1, AUTOINC ? 4'd8 : 4'd7);
      byte_rd_i = 8'h33; rd_reg_full = 1'b1;
      applyStimulus();
      checkOutput("f_d2_rd_clr", 16'(rd_clr), 16'h1);
      checkOutput("f_d2_addr", 16'(i2c_wr_addr), AUTOINC ? 16'd9 : 16'd7);
      applyStimulus();
      checkOutput("f_rd_clr_gap", 16'(rd_clr), 16'h0);
      checkOutput("f_stb_gap", 16'(i2c_wr_stb), 16'h0);
      rd_reg_full = 1'b0;
      stopTxn();
      readUsr(4'd7, "f_reg7", AUTOINC ? 8'h31 : 8'h33);
      readUsr(4'd8, "f_reg8", AUTOINC ? 8'h32 : 8'h00);

      // Asynchronous reset mid-transfer
      startTxn(1'b0);
      sendByte(8'h02, "g_ptr", 1'b0, 4'd0);
      byte_rd_i = 8'hEE; rd_reg_full = 1'b1;
      rst_n = 1'b0;
      #1;
      checkOutput("g_rst_busy", 16'(busy), 16'h0);
      applyStimulus();
      rst_n = 1'b1;
      applyStimulus();
      checkOutput("g_no_pulse", {14'h0, rd_clr, i2c_wr_stb}, 16'h0);
      rd_reg_full = 1'b0;
      readUsr(4'd3, "g_reg_clr", 8'h00);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/i2c_slave_reg_ctrl.md
# i2c_slave_reg_ctrl

Register-bank controller that sequences the `I2C_slave` byte engine. It owns the slave's receive/transmit handshakes and a REG_NUM x 8 register file. It interprets the I2C byte stream as "pointer byte, then data bytes with auto-increment", and gives local logic a synchronous access port to the same registers.

## Interface
Parameters:
- `REG_NUM`, 16: register count; power of two, 2..256.
- `ADDR_W`, 4: pointer width; equals log2(REG_NUM).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  block enable; registered into `slave_en`.
- `slave_en`  out  1  to slave `slave_en`.
- `rd_clr`  out  1  one-cycle pulse; acknowledges a received byte.
- `wr_rdy`  out  1  one-cycle pulse; `byte_wr_o` is valid.
- `byte_wr_o`  out  8  transmit byte to the slave.
- `rd_reg_full`, `wr_reg_empty`  in  1 each  slave buffer status.
- `byte_rd_i`  in  8  received byte from the slave.
- `addr_match`, `trans_dir`, `get_nack`, `trans_stop`, `bus_err`  in  1 each  slave status.
- `usr_we`  in  1  local write strobe.
- `usr_addr`  in  ADDR_W  local address.
- `usr_wdata`  in  8  local write data.
- `usr_rdata`  out  8  registered read data, `reg[usr_addr]`, one cycle latency.
- `i2c_wr_stb`  out  1  one-cycle pulse when I2C writes a register.
- `i2c_wr_addr`  out  ADDR_W  address of that write.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `err`  out  1  sticky on `bus_err`; cleared only by reset or by `en`=0.

## Operation
- FSM states: IDLE, PTR, WDATA, RDATA, DONE.
- IDLE: on a rising edge of `addr_match` with `trans_dir`=0, go to PTR. With `trans_dir`=1, go to RDATA.
- PTR: the first received byte loads `ptr` from bits [ADDR_W-1:0] of the byte; upper bits are ignored. Go to WDATA. No register is written.
- WDATA: each received byte writes `reg[ptr]`, pulses `i2c_wr_stb` with `i2c_wr_addr`=`ptr`, then advances `ptr`.
- RDATA: on each `wr_reg_empty`, with `wr_rdy` low in the previous cycle, load `byte_wr_o`=`reg[ptr]`, pulse `wr_rdy`, then advance `ptr`. The prefetched byte counts; `ptr` is not rolled back.
- RDATA on `get_nack`: go to DONE; no further `wr_rdy`.
- Any state on `trans_stop` or `bus_err`: go to IDLE. `ptr` is retained across transactions.
- Repeated start (new `addr_match` rise while busy): re-enter PTR or RDATA according to `trans_dir`. A write, repeated start, read sequence therefore reads from the pointer just written.
- Receive handshake, any non-IDLE state: when `rd_reg_full`=1 and `trans_dir`=0, pulse `rd_clr` and capture `byte_rd_i` in the same edge. `rd_clr` is never high two cycles in a row.
- Pointer arithmetic: modulo REG_NUM; REG_NUM-1 wraps to 0.
- Collision: if `usr_we` and an I2C write hit the same address in the same cycle, the I2C write wins. `usr_we` to other addresses proceeds.
- `en`=0 forces the FSM to IDLE, deasserts `slave_en` the next cycle, and clears `err`.

## Timing
- Reset values: all outputs 0; every register 0; `ptr`=0; state IDLE.
- `rd_clr` asserts the cycle after `rd_reg_full` is sampled high. The register write and `i2c_wr_stb` occur on that same edge.
- `wr_rdy` and `byte_wr_o` assert the cycle after `wr_reg_empty` is sampled high. `byte_wr_o` holds until the next load.
- `usr_rdata` reflects the register contents at the preceding edge, including a same-cycle I2C write (write-first).
- Reset asserted mid-transfer clears state immediately; no pulse is emitted after reset.

## Configuration
- `I2C_REG_AUTOINC_EN` defined: `ptr` increments after each I2C data write and each transmit load.
- Not defined: `ptr` changes only in PTR. Repeated accesses hit a single register (FIFO-port style).

## Structure
- Shared package `i2c_pkg`:
  - FSM state enum.
  - `I2C_REG_NUM_DEF` = 16.
  - `I2C_PTR_W_DEF` = 4.
- Sub-module `i2c_reg_file`: REG_NUM x 8 register file with one I2C write port, one local write port, two read ports, and the collision priority above.

## Test plan
- Write `{0x03, 0xA5, 0x5A}` -> reg[3]=0xA5, reg[4]=0x5A. Two `i2c_wr_stb` pulses with addresses 3 and 4; `ptr`=5.
- Pointer 0x0F, then write 0x11 and 0x22 -> reg[15]=0x11, reg[0]=0x22 (wrap).
- Write pointer 0x02, repeated start, read 2 bytes with the last NACKed -> bytes reg[2], reg[3]. State DONE, then IDLE on stop. No `wr_rdy` after `get_nack`.
- `usr_we` at addr 5 in the same cycle as an I2C write to addr 5 -> the I2C value is stored; `usr_rdata` shows it the next cycle.
- `bus_err` mid-WDATA -> IDLE and `err`=1. Deassert `en` -> `err`=0 and `slave_en`=0 one cycle later.
- `I2C_REG_AUTOINC_EN` undefined: pointer 0x07, then write 3 bytes -> only reg[7] changes, ending at the third byte.
